// File: rtl/gpmc_wb_width_bridge.sv
// gpmc_wb_width_bridge
// Adapts the 16-bit, halfword-addressed Wishbone master of the GPMC wrapper
// onto the 32-bit, word-addressed SoC Wishbone slave port. Each request is
// captured once, presented downstream from registered state, and either
// completed (ack / err), timed out, or abandoned by a master abort.
// TIMEOUT is expected in 1..65535 and BASE_ADDR must be 4-byte aligned.

module gpmc_wb_width_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int unsigned S_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    reset,

    // GPMC-side 16-bit slave port
    input  logic [S_ADDR_WIDTH-1:0] s_adr,
    input  logic [15:0]             s_dat_w,
    output logic [15:0]             s_dat_r,
    input  logic                    s_cyc,
    input  logic                    s_stb,
    input  logic                    s_we,
    output logic                    s_ack,

    // SoC-side 32-bit master port
    output logic [29:0]             m_adr,
    output logic [31:0]             m_dat_w,
    input  logic [31:0]             m_dat_r,
    output logic [3:0]              m_sel,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    input  logic                    m_ack,
    input  logic                    m_err,
    output logic [2:0]              m_cti,
    output logic [1:0]              m_bte,

    // Sticky error reporting
    output logic                    err_flag,
    input  logic                    err_clr
);

    localparam int unsigned S_DW  = 16;
    localparam int unsigned M_DW  = 32;
    localparam int unsigned M_AW  = 30;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 16;

    // SoC word address of the first halfword of the GPMC window
    localparam logic [M_AW-1:0]  BASE_WORD = M_AW'(BASE_ADDR >> 2);
    // Counter value seen in the last permitted REQ cycle
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [S_DW-1:0]  ERR_DATA  = 16'hDEAD;
    localparam logic [SEL_W-1:0] SEL_LO    = 4'b0011;
    localparam logic [SEL_W-1:0] SEL_HI    = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request as presented on the SoC side, plus the halfword lane
    typedef struct packed {
        logic [M_AW-1:0]  adr;
        logic [SEL_W-1:0] sel;
        logic [M_DW-1:0]  dat_w;
        logic             we;
        logic             hi;
    } req_t;

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_cyc_q, m_cyc_d;
    logic             s_ack_q, s_ack_d;
    logic [S_DW-1:0]  s_dat_r_q, s_dat_r_d;
    logic             err_flag_q, err_flag_d;
    logic             err_set;

    // Next-state, request capture, response steering and error bookkeeping
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        m_cyc_d   = m_cyc_q;
        s_ack_d   = 1'b0;
        s_dat_r_d = s_dat_r_q;
        err_set   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                m_cyc_d = 1'b0;
                if (s_cyc && s_stb) begin
                    req_d.adr   = BASE_WORD + M_AW'(s_adr >> 1);
                    req_d.sel   = s_adr[0] ? SEL_HI : SEL_LO;
                    req_d.dat_w = {s_dat_w, s_dat_w};
                    req_d.we    = s_we;
                    req_d.hi    = s_adr[0];
                    cnt_d       = '0;
                    m_cyc_d     = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ: begin
                if (!s_cyc) begin
                    // Master abandoned the cycle: drop the SoC side quietly
                    m_cyc_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (m_err || (!m_ack && (cnt_q == CNT_LAST))) begin
                    // Bus error or timeout both return the error pattern
                    s_dat_r_d = ERR_DATA;
                    err_set   = 1'b1;
                    s_ack_d   = 1'b1;
                    m_cyc_d   = 1'b0;
                    state_d   = ST_RESP;
                end else if (m_ack) begin
                    if (req_q.we) begin
                        s_dat_r_d = '0;
                    end else if (req_q.hi) begin
                        s_dat_r_d = m_dat_r[31:16];
                    end else begin
                        s_dat_r_d = m_dat_r[15:0];
                    end
                    s_ack_d = 1'b1;
                    m_cyc_d = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                m_cyc_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                m_cyc_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a simultaneous clear
        if (err_set) begin
            err_flag_d = 1'b1;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            m_cyc_q    <= 1'b0;
            s_ack_q    <= 1'b0;
            s_dat_r_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            m_cyc_q    <= m_cyc_d;
            s_ack_q    <= s_ack_d;
            s_dat_r_q  <= s_dat_r_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign m_adr    = req_q.adr;
    assign m_sel    = req_q.sel;
    assign m_dat_w  = req_q.dat_w;
    assign m_we     = req_q.we;
    assign m_cyc    = m_cyc_q;
    assign m_stb    = m_cyc_q;
    assign s_ack    = s_ack_q;
    assign s_dat_r  = s_dat_r_q;
    assign err_flag = err_flag_q;
    assign m_cti    = 3'b000;
    assign m_bte    = 2'b00;

endmodule

// File: tb/tb_gpmc_wb_width_bridge.sv
// Bench for gpmc_wb_width_bridge: transaction-level expectations derived
// from the bridge's rules, checked every cycle, plus directed literal checks.

module tb_gpmc_wb_width_bridge;

    localparam int unsigned  TMO  = 8;
    localparam logic [31:0]  BASE = 32'h4000_0000;

    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_TMO   = 3;
    localparam int K_ABORT = 4;
    localparam int K_RST   = 5;

    logic        clk;
    logic        reset;
    logic [15:0] s_adr;
    logic [15:0] s_dat_w;
    logic [15:0] s_dat_r;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [29:0] m_adr;
    logic [31:0] m_dat_w, m_dat_r;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        err_flag, err_clr;

    gpmc_wb_width_bridge #(
        .BASE_ADDR    (BASE),
        .S_ADDR_WIDTH (16),
        .TIMEOUT      (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_dat_r  (s_dat_r),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_ack    (s_ack),
        .m_adr    (m_adr),
        .m_dat_w  (m_dat_w),
        .m_dat_r  (m_dat_r),
        .m_sel    (m_sel),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_cti    (m_cti),
        .m_bte    (m_bte),
        .err_flag (err_flag),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Expected per-cycle outputs, set by the driver from the transaction plan
    logic        chk_en   = 1'b0;
    logic        exp_cyc  = 1'b0;
    logic        exp_ack  = 1'b0;
    logic        exp_zero = 1'b0;
    logic        exp_err  = 1'b0;
    logic        exp_we   = 1'b0;
    logic [29:0] exp_adr  = '0;
    logic [3:0]  exp_sel  = '0;
    logic [31:0] exp_datw = '0;
    logic [15:0] exp_rdat = '0;
    logic        rand_clr = 1'b0;

    // Observations of the last transaction for literal checks
    int          obs_stb;
    int          obs_ack;
    logic [29:0] obs_adr;
    logic [3:0]  obs_sel;
    logic [31:0] obs_datw;
    logic [15:0] obs_rdat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the expected state
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cyc", 32'(m_cyc), 32'(exp_cyc));
            chk("m_stb", 32'(m_stb), 32'(exp_cyc));
            chk("s_ack", 32'(s_ack), 32'(exp_ack));
            chk("err_flag", 32'(err_flag), 32'(exp_err));
            chk("m_cti", 32'(m_cti), 32'd0);
            chk("m_bte", 32'(m_bte), 32'd0);
            if (exp_cyc) begin
                chk("m_adr", 32'(m_adr), 32'(exp_adr));
                chk("m_sel", 32'(m_sel), 32'(exp_sel));
                chk("m_dat_w", m_dat_w, exp_datw);
                chk("m_we", 32'(m_we), 32'(exp_we));
            end
            if (exp_ack) begin
                chk("s_dat_r", 32'(s_dat_r), 32'(exp_rdat));
            end
            if (exp_zero) begin
                chk("zero_m_adr", 32'(m_adr), 32'd0);
                chk("zero_m_sel", 32'(m_sel), 32'd0);
                chk("zero_m_dat_w", m_dat_w, 32'd0);
                chk("zero_m_we", 32'(m_we), 32'd0);
                chk("zero_s_dat_r", 32'(s_dat_r), 32'd0);
            end
        end
    end

    // End one cycle: advance the sticky-error model at the edge
    task automatic tick(input logic set_ev);
        @(posedge clk);
        if (!reset)       exp_err = 1'b0;
        else if (set_ev)  exp_err = 1'b1;
        else if (err_clr) exp_err = 1'b0;
        #1;
        err_clr = rand_clr ? ($urandom_range(0, 3) == 0) : 1'b0;
        m_dat_r = $urandom();
    endtask

    task automatic sample(input int c);
        @(negedge clk);
        if (m_stb) obs_stb++;
        if (s_ack && obs_ack < 0) obs_ack = c;
        if (s_ack) obs_rdat = s_dat_r;
        if (c == 1) begin
            obs_adr  = m_adr;
            obs_sel  = m_sel;
            obs_datw = m_dat_w;
        end
    endtask

    // One upstream transaction; 'last' is the final REQ cycle of the plan
    task automatic txn(input logic [15:0] adr, input logic [15:0] wd, input logic we,
                       input int kind, input int lat, input logic [31:0] rd);
        int   last;
        logic set_ev;
        last    = (kind == K_TMO) ? int'(TMO) : lat;
        obs_stb = 0;
        obs_ack = -1;

        s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_dat_w = wd; s_we = we;
        exp_cyc = 1'b0; exp_ack = 1'b0; exp_zero = 1'b0;
        sample(0);
        tick(1'b0);

        exp_adr  = 30'((BASE >> 2) + 32'(adr >> 1));
        exp_sel  = adr[0] ? 4'b1100 : 4'b0011;
        exp_datw = {wd, wd};
        exp_we   = we;
        for (int c = 1; c <= last; c++) begin
            exp_cyc = 1'b1;
            m_ack = (kind == K_ACK || kind == K_BOTH) && (c == last);
            m_err = (kind == K_ERR || kind == K_BOTH) && (c == last);
            if (c == last) m_dat_r = rd;
            if (kind == K_ABORT && c == last) begin s_cyc = 1'b0; s_stb = 1'b0; end
            if (kind == K_RST && c == last) reset = 1'b0;
            sample(c);
            set_ev = (c == last) && (kind == K_ERR || kind == K_BOTH || kind == K_TMO);
            tick(set_ev);
        end
        m_ack = 1'b0;
        m_err = 1'b0;

        if (kind <= K_TMO) begin
            exp_cyc = 1'b0;
            exp_ack = 1'b1;
            if (kind != K_ACK)  exp_rdat = 16'hDEAD;
            else if (we)        exp_rdat = 16'h0000;
            else if (adr[0])    exp_rdat = rd[31:16];
            else                exp_rdat = rd[15:0];
            sample(last + 1);
            tick(1'b0);
            s_cyc = 1'b0; s_stb = 1'b0; exp_ack = 1'b0;
        end else begin
            s_cyc = 1'b0; s_stb = 1'b0; exp_cyc = 1'b0; exp_ack = 1'b0;
            if (kind == K_RST) exp_zero = 1'b1;
            reset = 1'b1;
            for (int c = 1; c <= 2; c++) begin
                sample(last + c);
                tick(1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        s_cyc = 1'b0; s_stb = 1'b0; exp_cyc = 1'b0; exp_ack = 1'b0;
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Check err_flag is up, pulse err_clr, check it dropped
    task automatic clr_pulse(input string name);
        err_clr = 1'b1;
        @(negedge clk);
        chk({name, "_set"}, 32'(err_flag), 32'd1);
        tick(1'b0);
        @(negedge clk);
        chk({name, "_clr"}, 32'(err_flag), 32'd0);
        tick(1'b0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int kind, lat, gap;
        reset = 1'b0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_adr = '0; s_dat_w = '0; m_dat_r = '0; m_ack = 1'b0; m_err = 1'b0;
        err_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        exp_err  = 1'b0;
        exp_zero = 1'b1;
        chk_en   = 1'b1;
        @(negedge clk);
        chk("rst_s_ack", 32'(s_ack), 32'd0);
        chk("rst_m_cyc", 32'(m_cyc), 32'd0);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);

        // Write to odd halfword, immediate ack
        txn(16'h0003, 16'hBEEF, 1'b1, K_ACK, 1, 32'h0);
        chk("wr_m_adr", 32'(obs_adr), 32'h1000_0001);
        chk("wr_m_sel", 32'(obs_sel), 32'h0000_000C);
        chk("wr_m_dat_w", obs_datw, 32'hBEEF_BEEF);
        chk("wr_ack_cycle", 32'(obs_ack), 32'd2);
        chk("wr_s_dat_r", 32'(obs_rdat), 32'h0);

        // Read from even halfword, three wait states
        txn(16'h0002, 16'h0000, 1'b0, K_ACK, 4, 32'h1234_5678);
        chk("rd_m_sel", 32'(obs_sel), 32'h0000_0003);
        chk("rd_s_dat_r", 32'(obs_rdat), 32'h0000_5678);
        chk("rd_ack_cycle", 32'(obs_ack), 32'd5);

        // Timeout with a silent slave
        txn(16'h0010, 16'h0000, 1'b0, K_TMO, 0, 32'h0);
        chk("tmo_stb_cycles", 32'(obs_stb), 32'd8);
        chk("tmo_ack_cycle", 32'(obs_ack), 32'd9);
        chk("tmo_s_dat_r", 32'(obs_rdat), 32'h0000_DEAD);
        clr_pulse("tmo_err_flag");

        // m_err and m_ack together
        txn(16'h0005, 16'h0000, 1'b0, K_BOTH, 2, 32'hFFFF_FFFF);
        chk("both_s_dat_r", 32'(obs_rdat), 32'h0000_DEAD);
        clr_pulse("both_err_flag");

        // Master abort in the 2nd REQ cycle, then a normal read
        txn(16'h0007, 16'h0000, 1'b0, K_ABORT, 2, 32'h0);
        chk("abort_stb_cycles", 32'(obs_stb), 32'd2);
        chk("abort_no_ack", 32'(obs_ack), 32'hFFFF_FFFF);
        txn(16'h0009, 16'h0000, 1'b0, K_ACK, 1, 32'hCAFE_0000);
        chk("post_abort_s_dat_r", 32'(obs_rdat), 32'h0000_CAFE);
        chk("post_abort_ack_cycle", 32'(obs_ack), 32'd2);

        // Reset asserted mid-REQ
        txn(16'h0004, 16'h1111, 1'b1, K_RST, 2, 32'h0);
        chk("rst_mid_no_ack", 32'(obs_ack), 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst_mid_m_adr", 32'(m_adr), 32'd0);
        tick(1'b0);

        // Randomized traffic with random error clears
        rand_clr = 1'b1;
        for (int t = 0; t < 400; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind > K_RST) kind = K_ACK;
            if (kind == K_ABORT || kind == K_RST) lat = int'($urandom_range(1, TMO - 1));
            else                                  lat = int'($urandom_range(1, TMO));
            txn(16'($urandom()), 16'($urandom()), 1'($urandom()), kind, lat, $urandom());
            gap = int'($urandom_range(0, 2));
            idle(gap);
        end
        rand_clr = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gpmc_wb_width_bridge.md
# gpmc_wb_width_bridge

Bridges the 16-bit Wishbone master produced by `gpmc_to_wishbone` onto the 32-bit, word-addressed Wishbone slave port of the LiteX SoC. It relocates GPMC halfword addresses into SoC space at `BASE_ADDR` and generates byte selects from the halfword lane. It steers read data back to 16 bits and aborts stalled cycles with a bounded timeout. It sits between the GPMC wrapper and the SoC Wishbone port in the top level, replacing the fixed address offset and constant `wb_sel` wiring there.

## Interface
- `BASE_ADDR`, 32'h4000_0000: SoC byte base address of the GPMC window; must be 4-byte aligned.
- `S_ADDR_WIDTH`, 16: GPMC-side halfword address width.
- `TIMEOUT`, 255: maximum cycles `m_stb` is held without `m_ack`/`m_err`; range 1..65535.
- `clk` in 1: system clock (clk100 domain). Single clock for the whole block.
- `reset` in 1: synchronous, active-low reset.
- `s_adr` in S_ADDR_WIDTH: halfword address from the GPMC wrapper.
- `s_dat_w` in 16: write data.
- `s_dat_r` out 16: read data, valid while `s_ack`=1.
- `s_cyc`, `s_stb`, `s_we` in 1: classic Wishbone cycle, strobe, and write enable.
- `s_ack` out 1: one-cycle completion pulse.
- `m_adr` out 30: SoC word address.
- `m_dat_w` out 32: write data.
- `m_dat_r` in 32: read data.
- `m_sel` out 4: byte lane selects.
- `m_cyc`, `m_stb`, `m_we` out 1: SoC-side cycle, strobe, and write enable.
- `m_ack`, `m_err` in 1: SoC-side completion and error.
- `m_cti` out 3: tied to 3'b000.
- `m_bte` out 2: tied to 2'b00.
- `err_flag` out 1: sticky; set on timeout or `m_err`.
- `err_clr` in 1: clears `err_flag`.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: when `s_cyc & s_stb`, register the request and go to REQ. Captured fields: `m_adr` = (BASE_ADDR>>2) + (s_adr>>1), `m_sel` = s_adr[0] ? 4'b1100 : 4'b0011, `m_dat_w` = {s_dat_w, s_dat_w}, `m_we` = s_we, lane bit `hi` = s_adr[0].
- Address arithmetic is 30-bit modulo 2^30. Wrap-around beyond the top is not flagged.
- REQ: `m_cyc` = `m_stb` = 1, both driven from registered state. The timeout counter increments each cycle.
  - `m_ack`: latch `s_dat_r` = hi ? m_dat_r[31:16] : m_dat_r[15:0]; go to RESP.
  - `m_err`: latch `s_dat_r` = 16'hDEAD, set `err_flag`; go to RESP.
  - If `m_ack` and `m_err` are both high, `m_err` wins.
  - Counter reaches TIMEOUT with neither response: same handling as `m_err`.
  - `s_cyc` = 0 (master abort): go to IDLE, no `s_ack`; `m_cyc`/`m_stb` deassert next cycle.
- RESP: `s_ack` = 1 for exactly one cycle; `m_cyc` = `m_stb` = 0; return to IDLE unconditionally. The upstream master drops `s_stb` on the cycle it samples `s_ack`, so no request is re-issued.
- `err_flag`: `err_clr` clears it. If a set event and `err_clr` occur in the same cycle, the set wins.
- Writes on the SoC side carry no readback; `s_dat_r` returns 16'h0000 on a successful write.

## Timing
- Reset values: state IDLE, `s_ack`=0, `s_dat_r`=0, `m_cyc`=`m_stb`=`m_we`=0, `m_adr`=0, `m_sel`=0, `m_dat_w`=0, `err_flag`=0, timeout counter 0.
- Reset asserted mid-REQ: all outputs take their reset values at the next edge; no `s_ack` is produced.
- Latency:
  - Request sampled at edge 0; `m_stb` high from cycle 1.
  - Slave acks in cycle k (k ≥ 1); `s_ack` is high in cycle k+1.
  - Minimum `s_stb`-to-`s_ack` is 2 cycles; zero-wait-state throughput is one transfer per 3 cycles.
- Timeout: `m_stb` is high for exactly TIMEOUT cycles; `s_ack` follows in the next cycle.
- All outputs except the constant `m_cti`/`m_bte` are registered.

## Test plan
- Write, odd address: s_adr=16'h0003, s_dat_w=16'hBEEF, s_we=1; slave acks on the first cycle. Expect m_adr=30'h1000_0001, m_sel=4'b1100, m_dat_w=32'hBEEF_BEEF, and `s_ack` 2 cycles after `s_stb`.
- Read, even address: s_adr=16'h0002; slave returns m_dat_r=32'h1234_5678 after 3 wait cycles. Expect m_sel=4'b0011, s_dat_r=16'h5678, and `s_ack` in cycle 5.
- Timeout: TIMEOUT=8 with the slave never responding. Expect `m_stb` high for exactly 8 cycles, then `s_ack` with s_dat_r=16'hDEAD and `err_flag`=1. Then pulse `err_clr` and expect `err_flag`=0.
- Error priority: `m_err` and `m_ack` asserted in the same cycle. Expect s_dat_r=16'hDEAD and `err_flag` set.
- Master abort: drop `s_cyc` in the 2nd REQ cycle. Expect `m_cyc`=0 the next cycle, no `s_ack`, and a following read completing normally.
- Reset mid-REQ: assert `reset`=0 during REQ. Expect all outputs at reset values after one edge, and no spurious `s_ack` after reset is released.
